// File: rtl/scratch_mem_responder.sv
// rtl/scratch_mem_responder.sv - 2-read/1-write scratch store with write-first forwarding and clear engine
module scratch_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  scratch_WE,
  input  logic [ADDR_WIDTH-1:0] scratch_write_addr,
  input  logic [DATA_WIDTH-1:0] scratch_wdata,
  input  logic                  scratch_RE0,
  input  logic [ADDR_WIDTH-1:0] scratch_read_addr0,
  input  logic                  scratch_RE1,
  input  logic [ADDR_WIDTH-1:0] scratch_read_addr1,
  output logic [DATA_WIDTH-1:0] scratch_rdata0,
  output logic [DATA_WIDTH-1:0] scratch_rdata1,
  output logic                  scratch_rvalid0,
  output logic                  scratch_rvalid1,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic                  wr_conflict
);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_W  = (ADDR_WIDTH + 1)'(DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH:0]   ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd0_next;
  logic [DATA_WIDTH-1:0] rd1_next;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_W);
  endfunction

  // The clear engine owns the write port for the whole CLEAR state.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = scratch_write_addr;
    wr_data = scratch_wdata;
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = ptr[ADDR_WIDTH-1:0];
      wr_data = '0;
    end else if (scratch_WE && in_range(scratch_write_addr)) begin
      wr_en = 1'b1;
    end
  end

  always_comb begin
    rd0_next = mem[scratch_read_addr0];
    if (!in_range(scratch_read_addr0))
      rd0_next = '0;
    else if (wr_en && (wr_addr == scratch_read_addr0))
      rd0_next = wr_data;
  end

  always_comb begin
    rd1_next = mem[scratch_read_addr1];
    if (!in_range(scratch_read_addr1))
      rd1_next = '0;
    else if (wr_en && (wr_addr == scratch_read_addr1))
      rd1_next = wr_data;
  end

  always_ff @(posedge clock) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      ptr             <= '0;
      scratch_rdata0  <= '0;
      scratch_rdata1  <= '0;
      scratch_rvalid0 <= 1'b0;
      scratch_rvalid1 <= 1'b0;
      clear_busy      <= 1'b0;
      clear_done      <= 1'b0;
      wr_conflict     <= 1'b0;
    end else begin
      scratch_rvalid0 <= scratch_RE0;
      scratch_rvalid1 <= scratch_RE1;
      if (scratch_RE0)
        scratch_rdata0 <= rd0_next;
      if (scratch_RE1)
        scratch_rdata1 <= rd1_next;
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_start) begin
            state      <= CLEAR;
            clear_busy <= 1'b1;
            ptr        <= '0;
          end
        end
        CLEAR: begin
          if (scratch_WE)
            wr_conflict <= 1'b1;
          if (ptr == LAST_W) begin
            state      <= DONE;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          ptr   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scratch_mem_responder.sv
// tb/tb_scratch_mem_responder.sv - scoreboard bench for scratch_mem_responder
module tb_scratch_mem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        scratch_WE;
  logic [7:0]  scratch_write_addr;
  logic [31:0] scratch_wdata;
  logic        scratch_RE0;
  logic [7:0]  scratch_read_addr0;
  logic        scratch_RE1;
  logic [7:0]  scratch_read_addr1;
  logic [31:0] scratch_rdata0;
  logic [31:0] scratch_rdata1;
  logic        scratch_rvalid0;
  logic        scratch_rvalid1;
  logic        clear_start;
  logic        clear_busy;
  logic        clear_done;
  logic        wr_conflict;

  int checks   = 0;
  int failures = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  scratch_mem_responder dut (
    .clock              (clock),
    .reset              (reset),
    .scratch_WE         (scratch_WE),
    .scratch_write_addr (scratch_write_addr),
    .scratch_wdata      (scratch_wdata),
    .scratch_RE0        (scratch_RE0),
    .scratch_read_addr0 (scratch_read_addr0),
    .scratch_RE1        (scratch_RE1),
    .scratch_read_addr1 (scratch_read_addr1),
    .scratch_rdata0     (scratch_rdata0),
    .scratch_rdata1     (scratch_rdata1),
    .scratch_rvalid0    (scratch_rvalid0),
    .scratch_rvalid1    (scratch_rvalid1),
    .clear_start        (clear_start),
    .clear_busy         (clear_busy),
    .clear_done         (clear_done),
    .wr_conflict        (wr_conflict)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Response monitor: pops one expectation per rvalid pulse.
  always @(negedge clock) begin
    if (scratch_rvalid0) begin
      if (q0.size() == 0) check("rvalid0_unexpected", 32'd1, 32'd0);
      else check("rdata0", scratch_rdata0, q0.pop_front());
    end
    if (scratch_rvalid1) begin
      if (q1.size() == 0) check("rvalid1_unexpected", 32'd1, 32'd0);
      else check("rdata1", scratch_rdata1, q1.pop_front());
    end
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic write(input logic [7:0] a, input logic [31:0] d);
    scratch_WE = 1'b1; scratch_write_addr = a; scratch_wdata = d;
    cycle();
    scratch_WE = 1'b0;
  endtask

  task automatic read0(input logic [7:0] a, input logic [31:0] exp);
    scratch_RE0 = 1'b1; scratch_read_addr0 = a; q0.push_back(exp);
    cycle();
    scratch_RE0 = 1'b0;
  endtask

  task automatic read1(input logic [7:0] a, input logic [31:0] exp);
    scratch_RE1 = 1'b1; scratch_read_addr1 = a; q1.push_back(exp);
    cycle();
    scratch_RE1 = 1'b0;
  endtask

  task automatic run_clear(input string tag);
    int busy_cnt, done_cnt, done_edge;
    busy_cnt = 0; done_cnt = 0; done_edge = -1;
    clear_start = 1'b1;
    cycle();
    clear_start = 1'b0;
    for (int e = 0; e <= 300; e++) begin
      if (clear_busy) busy_cnt++;
      if (clear_done) begin done_cnt++; done_edge = e; end
      cycle();
    end
    check({tag, "_busy_cycles"}, busy_cnt, 32'd256);
    check({tag, "_done_pulses"}, done_cnt, 32'd1);
    check({tag, "_done_edge"}, done_edge, 32'd256);
  endtask

  initial begin
    int busy_cnt, done_cnt, done_edge;
    reset = 1'b1; scratch_WE = 1'b0; scratch_write_addr = '0; scratch_wdata = '0;
    scratch_RE0 = 1'b0; scratch_read_addr0 = '0; scratch_RE1 = 1'b0; scratch_read_addr1 = '0;
    clear_start = 1'b0;
    repeat (3) cycle();
    check("reset_rdata0", scratch_rdata0, 32'd0);
    check("reset_rdata1", scratch_rdata1, 32'd0);
    check("reset_rvalid", {scratch_rvalid0, scratch_rvalid1}, 32'd0);
    check("reset_busy_done", {clear_busy, clear_done}, 32'd0);
    check("reset_wr_conflict", wr_conflict, 32'd0);
    reset = 1'b0;
    cycle();

    // Full clear then sweep every address on both ports.
    run_clear("clear1");
    for (int i = 0; i < 256; i++) begin
      scratch_RE0 = 1'b1; scratch_read_addr0 = 8'(i);       q0.push_back(32'd0);
      scratch_RE1 = 1'b1; scratch_read_addr1 = 8'(255 - i); q1.push_back(32'd0);
      cycle();
    end
    scratch_RE0 = 1'b0; scratch_RE1 = 1'b0;
    cycle();
    check("rvalid_drops", {scratch_rvalid0, scratch_rvalid1}, 32'd0);

    write(8'h10, 32'hDEADBEEF);
    read0(8'h10, 32'hDEADBEEF);

    // Same-cycle write and dual read of one address.
    scratch_WE = 1'b1; scratch_write_addr = 8'h22; scratch_wdata = 32'd5;
    scratch_RE0 = 1'b1; scratch_read_addr0 = 8'h22; q0.push_back(32'd5);
    scratch_RE1 = 1'b1; scratch_read_addr1 = 8'h22; q1.push_back(32'd5);
    cycle();
    scratch_WE = 1'b0; scratch_RE0 = 1'b0; scratch_RE1 = 1'b0;
    read1(8'h22, 32'd5);

    // Histogram read-modify-write on bin 7.
    write(8'h07, 32'd3);
    read0(8'h07, 32'd3);
    scratch_WE = 1'b1; scratch_write_addr = 8'h07; scratch_wdata = 32'd4;
    scratch_RE0 = 1'b1; scratch_read_addr0 = 8'h07; q0.push_back(32'd4);
    cycle();
    scratch_WE = 1'b0; scratch_RE0 = 1'b0;
    read1(8'h07, 32'd4);

    // Clear with external traffic.
    write(8'h05, 32'h55);
    write(8'd200, 32'hC8C8);
    write(8'h30, 32'h1234);
    check("conflict_before", wr_conflict, 32'd0);
    busy_cnt = 0; done_cnt = 0; done_edge = -1;
    clear_start = 1'b1;
    cycle();
    clear_start = 1'b0;
    for (int e = 0; e <= 300; e++) begin
      if (clear_busy) busy_cnt++;
      if (clear_done) begin done_cnt++; done_edge = e; end
      case (e)
        4:    begin scratch_WE = 1'b1; scratch_write_addr = 8'h05; scratch_wdata = 32'h99; end
        9:    begin scratch_RE1 = 1'b1; scratch_read_addr1 = 8'd200; q1.push_back(32'hC8C8); end
        8'h30: begin scratch_RE0 = 1'b1; scratch_read_addr0 = 8'h30; q0.push_back(32'd0); end
        199:  begin scratch_WE = 1'b1; scratch_write_addr = 8'h03; scratch_wdata = 32'h99; end
        default: ;
      endcase
      cycle();
      scratch_WE = 1'b0; scratch_RE0 = 1'b0; scratch_RE1 = 1'b0;
    end
    check("clear2_busy_cycles", busy_cnt, 32'd256);
    check("clear2_done_edge", done_edge, 32'd256);
    check("conflict_after", wr_conflict, 32'd1);
    read0(8'h05, 32'd0);
    read1(8'h03, 32'd0);
    read0(8'd200, 32'd0);

    // Reset in the middle of a clear.
    write(8'd200, 32'h200A);
    write(8'd150, 32'd7);
    write(8'd50, 32'd5);
    clear_start = 1'b1;
    cycle();
    clear_start = 1'b0;
    repeat (100) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("midreset_busy", clear_busy, 32'd0);
    check("midreset_conflict", wr_conflict, 32'd0);
    done_cnt = 0; busy_cnt = 0;
    for (int e = 0; e < 300; e++) begin
      if (clear_done) done_cnt++;
      if (clear_busy) busy_cnt++;
      cycle();
    end
    check("midreset_no_done", done_cnt, 32'd0);
    check("midreset_no_busy", busy_cnt, 32'd0);
    read0(8'd200, 32'h200A);
    read1(8'd150, 32'd7);
    read0(8'd50, 32'd0);
    run_clear("clear3");
    read0(8'd200, 32'd0);
    read1(8'd150, 32'd0);
    cycle();
    cycle();

    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
